inst_encoder: RTL and testbench

Pipelined RISC-V instruction encoder: accepts decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit instruction word. It performs the inverse of the core's immediate extraction. Output words carry a sequential instruction-memory byte address. The block feeds imem preload and self-check benches, and provides the packing path for the planned on-chip patch loader.

---
 rtl/inst_encoder_if.sv | 32 +++
 rtl/inst_encoder.sv | 132 +++++++++++++
 tb/tb_inst_encoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Handshake and field bundle for inst_encoder: decoded fields in, packed word plus address out.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] err_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output addr_clr, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  addr_clr, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_encoder.sv
// RISC-V field packer, two register stages (S1 fields/flags, S2 packed word); in_ready drops only when both stages hold and out_ready=0.
// Define IMM_RANGE_CHECK_EN to turn unrepresentable immediates into flagged NOPs instead of truncating them.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rstn,
  inst_encoder_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  function automatic logic [31:0] pack(input fields_t f);
    logic [31:0] w;
    w = NOP;
    case (f.fmt)
      3'd0:    w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      3'd1:    w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      3'd2:    w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      3'd3:    w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11], f.opcode};
      3'd4:    w = {f.imm[31:12], f.rd, f.opcode};
      3'd5:    w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = NOP;
    endcase
    return w;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  fields_t     s1_fld_q, s1_fld_d;
  logic        s1_err_q, s1_err_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_err_q, s2_err_d;
  logic [31:0] s2_addr_q, s2_addr_d;
  logic [31:0] nxt_addr_q, nxt_addr_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        s1_adv, in_rdy, s2_load, out_hs, in_err;
  fields_t     in_fld;

  always_comb begin
    s1_adv  = !s2_valid_q || bus.out_ready;
    in_rdy  = !s1_valid_q || s1_adv;
    s2_load = s1_valid_q && s1_adv;
    out_hs  = s2_valid_q && bus.out_ready;
    in_fld  = '{fmt: bus.in_fmt, opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                rs2: bus.in_rs2, funct3: bus.in_funct3, funct7: bus.in_funct7, imm: bus.in_imm};

    in_err = (in_fld.fmt > 3'd5);
`ifdef IMM_RANGE_CHECK_EN
    case (in_fld.fmt)
      3'd1, 3'd2: in_err = (in_fld.imm[31:11] != {21{in_fld.imm[11]}});
      3'd3:       in_err = in_fld.imm[0] || (in_fld.imm[31:12] != {20{in_fld.imm[12]}});
      3'd4:       in_err = (in_fld.imm[11:0] != 12'd0);
      3'd5:       in_err = in_fld.imm[0] || (in_fld.imm[31:20] != {12{in_fld.imm[20]}});
      default:    ;
    endcase
`endif

    s1_valid_d = s1_valid_q;
    s1_fld_d   = s1_fld_q;
    s1_err_d   = s1_err_q;
    if (in_rdy) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_fld_d = in_fld;
        s1_err_d = in_err;
      end
    end

    // The address is bound when a word enters S2, so a clear never disturbs a held word.
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;
    s2_addr_d  = s2_addr_q;
    nxt_addr_d = nxt_addr_q;
    if (s2_load) begin
      s2_inst_d  = s1_err_q ? NOP : pack(s1_fld_q);
      s2_err_d   = s1_err_q;
      s2_addr_d  = bus.addr_clr ? BASE_ADDR : nxt_addr_q;
      nxt_addr_d = s2_addr_d + 32'd4;
    end else if (bus.addr_clr) begin
      nxt_addr_d = BASE_ADDR;
    end

    err_cnt_d = err_cnt_q;
    if (out_hs && s2_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_fld_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_addr_q  <= BASE_ADDR;
      nxt_addr_q <= BASE_ADDR;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fld_q   <= s1_fld_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_err_q   <= s2_err_d;
      s2_addr_q  <= s2_addr_d;
      nxt_addr_q <= nxt_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_inst  = s2_inst_q;
  assign bus.out_addr  = s2_addr_q;
  assign bus.out_err   = s2_err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes hand-computed words, monitors pop and compare on output.
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  inst_encoder_if bus ();
  inst_encoder_if bus2 ();

  inst_encoder dut (.clk(clk), .rstn(rstn), .bus(bus));
  inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (.clk(clk), .rstn(rstn), .bus(bus2));

  typedef struct { logic [31:0] inst; logic [31:0] addr; logic err; } exp_t;
  exp_t q[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int exp_errcnt = 0;
  bit send_done = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] addi_word(input int i);
    return {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %08h at %08h, expected none", bus.out_inst, bus.out_addr);
        end else begin
          // Also runs while stalled: held outputs must keep matching the head entry.
          chk("out_inst", bus.out_inst, q[0].inst);
          chk("out_addr", bus.out_addr, q[0].addr);
          chk("out_err", 32'(bus.out_err), 32'(q[0].err));
          chk("err_cnt", 32'(bus.err_cnt), 32'(exp_errcnt));
          if (bus.out_ready) begin
            if (q[0].err && exp_errcnt < 32'hFFFF) exp_errcnt++;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wrap_unexpected: got %08h, expected none", bus2.out_inst);
        end else begin
          chk("wrap_inst", bus2.out_inst, q2[0].inst);
          chk("wrap_addr", bus2.out_addr, q2[0].addr);
          void'(q2.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] e_inst, input logic [31:0] e_addr, input logic e_err);
    int n;
    bit ok;
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (ok) begin
      q.push_back('{e_inst, e_addr, e_err});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", n);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_addi(input int i, input logic [31:0] e_addr);
    send(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), addi_word(i), e_addr, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", q.size());
    end
    #1;
  endtask

  task automatic check_latency();
    chk("lat_one_edge_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_two_edge_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic pulse_clr();
    bus.addr_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.addr_clr = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.in_fmt = '0;    bus.in_opcode = '0; bus.in_rd = '0;
    bus.in_rs1 = '0;      bus.in_rs2 = '0;    bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_imm = '0;      bus.addr_clr = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_fmt = 3'd1; bus2.in_opcode = 7'h13; bus2.in_rd = '0;
    bus2.in_rs1 = '0;     bus2.in_rs2 = '0;   bus2.in_funct3 = '0; bus2.in_funct7 = '0;
    bus2.in_imm = '0;     bus2.addr_clr = 1'b0; bus2.out_ready = 1'b0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_wrap_addr", bus2.out_addr, 32'hFFFF_FFFC);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single words of every format.
    bus.out_ready = 1'b1;
    pulse_clr();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 32'h0, 1'b0);
    check_latency();
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 32'h4, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 32'h8, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 32'hC, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 32'h10, 1'b0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 32'h14, 1'b0);
    drain();

    // Streaming under out_ready pattern 1,0,0,1.
    pulse_clr();
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_addi(i + 1, 32'(4 * i));
        send_done = 1'b1;
      end
      begin
        for (int c = 0; c < 300 && !(send_done && q.size() == 0); c++) begin
          bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Clear coinciding with the third handshake; the next word lands at the base.
    pulse_clr();
    send_addi(10, 32'h0);
    send_addi(11, 32'h4);
    drain();
    bus.out_ready = 1'b0;
    send_addi(12, 32'h8);
    send_addi(13, 32'h0);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    bus.addr_clr  = 1'b1;
    @(posedge clk);
    #1;
    bus.addr_clr = 1'b0;
    drain();

    // Error words: range violations only flagged when range checking is built in.
    pulse_clr();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, RC ? NOP : 32'h0000_0093, 32'h0, RC);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, RC ? NOP : 32'h0020_8163, 32'h4, RC);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, NOP, 32'h8, 1'b1);
    drain();
    chk("err_cnt_total", 32'(bus.err_cnt), RC ? 32'd3 : 32'd1);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send_addi(20, 32'hC);
    send_addi(21, 32'h10);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_addr", bus.out_addr, 32'd0);
    chk("arst_out_inst", bus.out_inst, 32'd0);
    chk("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    exp_errcnt = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
    bus.out_ready = 1'b1;
    send_addi(22, 32'h0);
    check_latency();
    drain();

    // Address wrap on an instance based at 0xFFFFFFFC.
    bus2.out_ready = 1'b1;
    bus2.addr_clr  = 1'b1;
    @(posedge clk);
    #1;
    bus2.addr_clr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_rd    = 5'(i);
      bus2.in_imm   = 32'(i);
      @(posedge clk);
      q2.push_back('{addi_word(i), 32'hFFFF_FFFC + 32'(4 * (i - 1)), 1'b0});
      #1;
    end
    bus2.in_valid = 1'b0;
    for (int n = 0; n < 50 && q2.size() != 0; n++) @(posedge clk);
    if (q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wrap_drain: %0d words pending, expected 0", q2.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
